demux1_8_deser: RTL and testbench

//   Receive-end counterpart of the 8:1 select-multiplexed serial link: a 1:8

---
 rtl/demux1_8_deser.sv | 94 +++++++++
 tb/tb_demux1_8_deser.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/demux1_8_deser.sv
// demux1_8_deser: 1:LANES time-division demultiplexer / deserializer.
// Each qualified bit is written to lane S. The word is published on O with a
// valid/ready handshake once the last lane is filled. A sticky overrun flag
// records when a completed word replaces one that was never consumed.
module demux1_8_deser #(
  parameter int LANES = 8,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic [SEL_W-1:0] S,
  output logic [LANES-1:0] O,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

  // Only lanes 0..LANES-2 need storage. The last bit goes straight into O.
  logic [SEL_W-1:0] sel_q,    sel_d;
  logic [LANES-2:0] shadow_q, shadow_d;
  logic [LANES-1:0] o_q,      o_d;
  logic             ov_q,     ov_d;
  logic             ovr_q,    ovr_d;
  logic             word_done;

  // Next-state logic: lane steering, word publication, handshake, overrun.
  always_comb begin
    sel_d     = sel_q;
    shadow_d  = shadow_q;
    o_d       = o_q;
    ov_d      = ov_q;
    ovr_d     = ovr_q;
    word_done = in_valid & ~sync & (sel_q == LAST);

    if (sync) begin
      // Realign: drop the partial word. A same-cycle bit becomes lane 0.
      shadow_d = '0;
      sel_d    = '0;
      if (in_valid) begin
        shadow_d[0] = in_bit;
        sel_d       = SEL_W'(1);
      end
    end else if (in_valid) begin
      if (sel_q != LAST) begin
        shadow_d[sel_q] = in_bit;
      end
      sel_d = sel_q + 1'b1;
    end

    // Apply the clear before the set so that a new overrun at the same edge wins.
    if (clr_ovr) begin
      ovr_d = 1'b0;
    end

    if (word_done) begin
      o_d  = {in_bit, shadow_q};
      ov_d = 1'b1;
      if (ov_q && !O_ready) begin
        ovr_d = 1'b1;
      end
    end else if (ov_q && O_ready) begin
      ov_d = 1'b0;
    end
  end

  // State registers. Reset clears every register, including the data path.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      shadow_q <= '0;
      o_q      <= '0;
      ov_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      o_q      <= o_d;
      ov_q     <= ov_d;
      ovr_q    <= ovr_d;
    end
  end

  assign S       = sel_q;
  assign O       = o_q;
  assign O_valid = ov_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_demux1_8_deser.sv
// Directed testbench for demux1_8_deser: reset, plain words, gapped input,
// sync realignment, overrun set/clear, same-edge handshake and mid-word reset.
module tb_demux1_8_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic [2:0] S;
  logic [7:0] O;
  logic       O_valid;
  logic       O_ready = 1'b0;
  logic       overrun;
  logic       clr_ovr = 1'b0;

  int checks = 0;
  int errors = 0;

  demux1_8_deser #(.LANES(8), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .sync(sync), .in_valid(in_valid), .in_bit(in_bit),
    .S(S), .O(O), .O_valid(O_valid), .O_ready(O_ready),
    .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock. Inputs are already set, and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) put(w[i]);
  endtask

  initial begin
    // Test 1: reset state, then 1,0,1,1,0,0,1,0 -> 0x4D
    tick();
    chk("rst_S", S, 0);
    chk("rst_O", O, 0);
    chk("rst_valid", O_valid, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    O_ready = 1'b1;
    put(1); put(0); put(1); put(1); put(0); put(0); put(1);
    chk("t1_S_mid", S, 7);
    chk("t1_valid_early", O_valid, 0);
    put(0);
    chk("t1_O", O, 8'h4D);
    chk("t1_valid", O_valid, 1);
    chk("t1_S_wrap", S, 0);
    tick();
    chk("t1_consumed", O_valid, 0);
    chk("t1_O_hold", O, 8'h4D);

    // Test 2: 0xA5 with in_valid toggling every cycle
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      in_bit   = in_valid ? 1'((8'hA5 >> (i / 2)) & 1) : 1'b0;
      tick();
      if (i == 5)  chk("t2_S_after_valid", S, 3);
      if (i == 6)  chk("t2_S_mid", S, 4);
      if (i == 7)  chk("t2_S_gap_hold", S, 4);
      if (i == 12) chk("t2_valid_early", O_valid, 0);
      if (i == 14) begin
        chk("t2_O", O, 8'hA5);
        chk("t2_valid", O_valid, 1);
      end
    end
    in_valid = 1'b0;
    chk("t2_consumed", O_valid, 0);

    // Test 3: 3 bits, then sync with a bit of 1, then 7 zeros -> 0x01
    put(1); put(1); put(1);
    chk("t3_S_partial", S, 3);
    sync = 1'b1;
    put(1);
    sync = 1'b0;
    chk("t3_S_sync", S, 1);
    chk("t3_no_partial", O_valid, 0);
    send_bits(8'h00, 6);
    chk("t3_valid_early", O_valid, 0);
    put(0);
    chk("t3_O", O, 8'h01);
    chk("t3_valid", O_valid, 1);
    tick();
    chk("t3_consumed", O_valid, 0);

    // Test 4: O_ready low, 0x11 then 0x22 -> overrun, then clear it
    O_ready = 1'b0;
    send_bits(8'h11, 8);
    chk("t4_O1", O, 8'h11);
    chk("t4_ovr_first", overrun, 0);
    tick();
    chk("t4_O_stable", O, 8'h11);
    chk("t4_valid_held", O_valid, 1);
    send_bits(8'h22, 8);
    chk("t4_O2", O, 8'h22);
    chk("t4_valid2", O_valid, 1);
    chk("t4_ovr_set", overrun, 1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("t4_ovr_clr", overrun, 0);
    chk("t4_valid_after_clr", O_valid, 1);

    // Test 5: consume 0x22, 0x33 pending, 0x44 completes with O_ready=1
    O_ready = 1'b1;
    tick();
    chk("t5_consumed", O_valid, 0);
    O_ready = 1'b0;
    send_bits(8'h33, 8);
    chk("t5_O33", O, 8'h33);
    chk("t5_ovr_none", overrun, 0);
    send_bits(8'h44, 7);
    O_ready = 1'b1;
    put(0);
    chk("t5_O44", O, 8'h44);
    chk("t5_valid_stays", O_valid, 1);
    chk("t5_ovr_stays0", overrun, 0);

    // Overrun set and clr_ovr at the same edge: set wins
    O_ready = 1'b0;
    send_bits(8'h55, 7);
    clr_ovr = 1'b1;
    put(0);
    clr_ovr = 1'b0;
    chk("t5_set_wins", overrun, 1);
    chk("t5_O55", O, 8'h55);

    // Test 6: reset mid-word with O_valid=1 and overrun=1
    send_bits(8'hFF, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_S", S, 0);
    chk("t6_O", O, 0);
    chk("t6_valid", O_valid, 0);
    chk("t6_ovr", overrun, 0);
    O_ready = 1'b1;
    send_bits(8'h96, 8);
    chk("t6_O_clean", O, 8'h96);
    chk("t6_valid_clean", O_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
